// File: rtl/bn_pkg.sv
// Shared batch-norm statistics definitions: default widths, Range-BN scale constant
// and the accumulate/compute state encoding.
package bn_pkg;

  localparam int BN_DATA_WIDTH  = 16;
  localparam int BN_MINI_BATCH  = 64;
  localparam int BN_SCALE_WIDTH = 8;
  localparam int BN_FRAC_BITS   = 8;
  localparam int BN_RANGE_SCALE = 44;

  // Downstream divides by the std-dev estimate, so it never drops below this.
  localparam int STD_MIN = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPUTE = 2'd2,
    SCALE   = 2'd3
  } state_t;

endpackage

// File: rtl/range_scale_sat.sv
// Range-BN sigma estimate: (range * C(n)) >> FRAC_BITS, saturated to the signed
// positive maximum and clamped to STD_MIN. Purely combinational.
module range_scale_sat
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH  = BN_DATA_WIDTH,
  parameter int SCALE_WIDTH = BN_SCALE_WIDTH,
  parameter int FRAC_BITS   = BN_FRAC_BITS
) (
  input  logic        [DATA_WIDTH-1:0]  range_val,
  input  logic        [SCALE_WIDTH-1:0] scale,
  output logic signed [DATA_WIDTH-1:0]  sigma
);

  localparam int PROD_W = DATA_WIDTH + SCALE_WIDTH;

  logic [PROD_W-1:0] prod;

  function automatic logic signed [DATA_WIDTH-1:0] sat_clamp(input logic [PROD_W-1:0] v);
    logic [PROD_W-1:0] pos_max;
    pos_max = PROD_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    if (v > pos_max)
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < PROD_W'(STD_MIN))
      return DATA_WIDTH'(STD_MIN);
    else
      return v[DATA_WIDTH-1:0];
  endfunction

  assign prod  = PROD_W'(range_val) * PROD_W'(scale);
  assign sigma = sat_clamp(prod >> FRAC_BITS);

endmodule

// File: rtl/range_stat_gen.sv
// Per-channel mini-batch statistics: accumulates MINI_BATCH signed samples and emits
// the floor mean plus a range-based std-dev estimate with a one-cycle valid pulse.
module range_stat_gen
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH  = BN_DATA_WIDTH,
  parameter int MINI_BATCH  = BN_MINI_BATCH,
  parameter int ADDR_WIDTH  = $clog2(MINI_BATCH),
  parameter int SCALE_WIDTH = BN_SCALE_WIDTH,
  parameter int FRAC_BITS   = BN_FRAC_BITS,
  parameter int RANGE_SCALE = BN_RANGE_SCALE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_in,
  input  logic                         data_valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         data_ready_out,
  output logic                         stats_valid_out,
  output logic signed [DATA_WIDTH-1:0] g_avg_out,
  output logic signed [DATA_WIDTH-1:0] g_stan_dev_out
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]        LAST_CNT = ADDR_WIDTH'(MINI_BATCH - 1);
  localparam logic signed [DATA_WIDTH-1:0] S_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (MINI_BATCH < 2 || (MINI_BATCH & (MINI_BATCH - 1)) != 0) begin : g_bad_batch
    $error("range_stat_gen: MINI_BATCH must be a power of two >= 2");
  end

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        count;
  logic signed [SUM_W-1:0]      sum_val;
  logic signed [DATA_WIDTH-1:0] max_val, min_val;
  logic                         accept, last;

  logic signed [DATA_WIDTH-1:0] avg_c, std_c;
  logic        [DATA_WIDTH-1:0] range_c;
  logic signed [DATA_WIDTH-1:0] avg_p1, std_p1;
  logic signed [DATA_WIDTH-1:0] avg_hold, std_hold;
  logic                         vld_p1;

  assign accept = data_valid_in && data_ready_out && !clear_in;
  assign last   = accept && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      data_ready_out <= 1'b1;
    end else begin
      state          <= state_nxt;
      data_ready_out <= (state_nxt == IDLE) || (state_nxt == ACCUM);
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = last ? COMPUTE : ACCUM;
        ACCUM:   if (last) state_nxt = COMPUTE;
        COMPUTE: state_nxt = SCALE;
        SCALE:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accumulation stage: counter, running sum, extrema.
  always_ff @(posedge clk) begin
    if (rst || clear_in || state == SCALE) begin
      count   <= '0;
      sum_val <= '0;
      max_val <= S_MIN;
      min_val <= S_MAX;
    end else if (accept) begin
      count   <= last ? '0 : count + 1'b1;
      sum_val <= sum_val + SUM_W'(data_in);
      if (data_in > max_val) max_val <= data_in;
      if (data_in < min_val) min_val <= data_in;
    end
  end

  assign avg_c   = DATA_WIDTH'(sum_val >>> ADDR_WIDTH);
  assign range_c = max_val - min_val;

  range_scale_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_scale (
    .range_val(range_c),
    .scale    (SCALE_WIDTH'(RANGE_SCALE)),
    .sigma    (std_c)
  );

  // Compute stage (p1): results registered at the end of COMPUTE, committed to the
  // held outputs at the end of SCALE unless that cycle was cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_p1   <= '0;
      std_p1   <= '0;
      avg_hold <= '0;
      std_hold <= '0;
    end else begin
      if (state == COMPUTE) begin
        avg_p1 <= avg_c;
        std_p1 <= std_c;
      end
      if (state == SCALE && !clear_in) begin
        avg_hold <= avg_p1;
        std_hold <= std_p1;
      end
    end
  end

  assign vld_p1 = (state == SCALE);

  always_comb begin
    stats_valid_out = vld_p1 && !clear_in;
    g_avg_out       = stats_valid_out ? avg_p1 : avg_hold;
    g_stan_dev_out  = stats_valid_out ? std_p1 : std_hold;
  end

endmodule

// File: tb/tb_range_stat_gen.sv
// Randomized bench for range_stat_gen: batches of samples against a behavioural
// mean/range model, with gaps, clears at every stage and mid-batch reset.
module tb_range_stat_gen;

  localparam int MB = 64;

  logic clk = 1'b0;
  logic rst;
  logic clear_in;
  logic data_valid_in;
  logic signed [15:0] data_in;
  logic data_ready_out, stats_valid_out;
  logic signed [15:0] g_avg_out, g_stan_dev_out;
  logic ready_s, vld_s;
  logic signed [15:0] avg_s, std_s;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int smp[$];
  longint last_avg = 0, last_std = 0, last_std_s = 0;

  always #5 clk = ~clk;

  range_stat_gen dut (
    .clk(clk), .rst(rst), .clear_in(clear_in), .data_valid_in(data_valid_in),
    .data_in(data_in), .data_ready_out(data_ready_out), .stats_valid_out(stats_valid_out),
    .g_avg_out(g_avg_out), .g_stan_dev_out(g_stan_dev_out)
  );

  range_stat_gen #(.RANGE_SCALE(255)) dut_sat (
    .clk(clk), .rst(rst), .clear_in(clear_in), .data_valid_in(data_valid_in),
    .data_in(data_in), .data_ready_out(ready_s), .stats_valid_out(vld_s),
    .g_avg_out(avg_s), .g_stan_dev_out(std_s)
  );

  always @(negedge clk) if (stats_valid_out) pulses++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mean is floor(sum / n); std is floor(range * scale / 256) limited to [1, 32767].
  function automatic longint exp_avg();
    longint s, q;
    s = 0;
    foreach (smp[i]) s += smp[i];
    q = s / MB;
    if ((s % MB) != 0 && s < 0) q -= 1;
    return q;
  endfunction

  function automatic longint exp_std(input int scale);
    longint mx, mn, p;
    mx = -32768;
    mn = 32767;
    foreach (smp[i]) begin
      if (smp[i] > mx) mx = smp[i];
      if (smp[i] < mn) mn = smp[i];
    end
    p = ((mx - mn) * scale) / 256;
    if (p > 32767) p = 32767;
    if (p < 1) p = 1;
    return p;
  endfunction

  task automatic tick(input logic v, input int d, input logic c);
    data_valid_in = v;
    data_in = 16'(d);
    clear_in = c;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit gaps);
    foreach (smp[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick(1'b0, 0, 1'b0);
          check("ready_gap", data_ready_out, 1);
          check("vld_gap", stats_valid_out, 0);
          adv();
        end
      end
      tick(1'b1, smp[i], 1'b0);
      check("ready_accept", data_ready_out, 1);
      adv();
    end
  endtask

  // mode 0: normal pulse, 1: clear during SCALE, 2: clear during COMPUTE
  task automatic finish_batch(input int mode);
    longint ea, es, ess;
    ea = exp_avg();
    es = exp_std(44);
    ess = exp_std(255);
    tick(1'b0, 0, mode == 2);
    check("ready_compute", data_ready_out, 0);
    check("sat_ready_compute", ready_s, 0);
    check("vld_compute", stats_valid_out, 0);
    adv();
    if (mode != 2) begin
      tick(1'b0, 0, mode == 1);
      check("ready_scale", data_ready_out, 0);
      if (mode == 1) begin
        check("vld_suppressed", stats_valid_out, 0);
        check("avg_kept", g_avg_out, last_avg);
        check("std_kept", g_stan_dev_out, last_std);
      end else begin
        check("vld_pulse", stats_valid_out, 1);
        check("sat_vld_pulse", vld_s, 1);
        check("avg", g_avg_out, ea);
        check("std", g_stan_dev_out, es);
        check("sat_avg", avg_s, ea);
        check("sat_std", std_s, ess);
        last_avg = ea;
        last_std = es;
        last_std_s = ess;
        exp_pulses++;
      end
      adv();
    end
    tick(1'b0, 0, 1'b0);
    check("ready_after", data_ready_out, 1);
    check("vld_after", stats_valid_out, 0);
    check("avg_held", g_avg_out, last_avg);
    check("std_held", g_stan_dev_out, last_std);
    check("sat_std_held", std_s, last_std_s);
    check("pulse_count", pulses, exp_pulses);
    adv();
    smp.delete();
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_in = 1'b0;
    data_valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b0, 0, 1'b0);
    check("rst_ready", data_ready_out, 1);
    check("rst_vld", stats_valid_out, 0);
    check("rst_avg", g_avg_out, 0);
    check("rst_std", g_stan_dev_out, 0);
    adv();

    // constant batch: zero range clamps to 1
    repeat (MB) smp.push_back(100);
    feed(1'b0);
    finish_batch(0);

    // ramp with gaps
    for (int i = -32; i < 32; i++) smp.push_back(i);
    feed(1'b1);
    finish_batch(0);

    // full-scale alternating: saturates on the 255 instance
    for (int i = 0; i < 32; i++) begin
      smp.push_back(-32768);
      smp.push_back(32767);
    end
    feed(1'b0);
    finish_batch(0);

    // clear together with a valid sample mid-batch
    repeat (10) smp.push_back(rnd_sample());
    feed(1'b0);
    tick(1'b1, 999, 1'b1);
    check("ready_on_clear", data_ready_out, 1);
    adv();
    smp.delete();
    tick(1'b0, 0, 1'b0);
    check("avg_after_clear", g_avg_out, last_avg);
    check("vld_after_clear", stats_valid_out, 0);
    adv();
    repeat (MB) smp.push_back(5);
    feed(1'b0);
    finish_batch(0);

    // reset after 40 gapped samples
    repeat (40) smp.push_back(rnd_sample());
    feed(1'b1);
    rst = 1'b1;
    tick(1'b0, 0, 1'b0);
    adv();
    rst = 1'b0;
    smp.delete();
    last_avg = 0;
    last_std = 0;
    last_std_s = 0;
    tick(1'b0, 0, 1'b0);
    check("midrst_ready", data_ready_out, 1);
    check("midrst_vld", stats_valid_out, 0);
    check("midrst_avg", g_avg_out, 0);
    check("midrst_std", g_stan_dev_out, 0);
    check("midrst_pulses", pulses, exp_pulses);
    adv();
    repeat (MB) smp.push_back(-7);
    feed(1'b1);
    finish_batch(0);

    // random batches, cycling through normal / clear-in-SCALE / clear-in-COMPUTE
    for (int b = 0; b < 9; b++) begin
      repeat (MB) smp.push_back(rnd_sample());
      feed(b[0]);
      finish_batch(b % 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
